// File: rtl/sdm_dwa_pkg.sv
// Shared constants for the sigma-delta DAC element-matching encoder.
package sdm_pkg;

    localparam int unsigned NB = 4;
    localparam int unsigned NE = 2 ** NB;
    localparam int unsigned PW = NB;

    localparam logic [1:0] MODE_THERM = 2'b00;
    localparam logic [1:0] MODE_DWA   = 2'b01;
    localparam logic [1:0] MODE_BIDWA = 2'b10;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_BWD = 1'b1;

    // Maps the signed code -2**(NB-1)..2**(NB-1)-1 onto an element count 0..NE-1.
    localparam logic [NB:0] OFFSET = (NB + 1)'(2 ** (NB - 1));

endpackage

// File: rtl/sdm_dwa_rotate.sv
// Combinational thermometer-mask generator and barrel rotator for DWA element selection.
module dwa_rotate #(
    parameter int unsigned NE = 16,
    parameter int unsigned PW = 4
) (
    input  logic [PW:0]   k,
    input  logic [PW-1:0] ptr,
    input  logic          dir,
    output logic [NE-1:0] vec
);

    logic [NE-1:0]   mask;
    logic [PW-1:0]   sh;
    logic [2*NE-1:0] dbl;

    // Backward selection ptr-1..ptr-k is the same mask rotated to start at ptr-k.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < NE; i++) begin
            mask[i] = ((PW + 1)'(i) < k);
        end
        sh  = dir ? (ptr - k[PW-1:0]) : ptr;
        dbl = {mask, mask} << sh;
        vec = dbl[2*NE-1:NE];
    end

endmodule

// File: rtl/sdm_dwa.sv
// Data-weighted-averaging encoder: signed modulator code to rotated unit-element enables.
module sdm_dwa
    import sdm_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [1:0]    mode,
    input  logic [NB-1:0] din,
    output logic [NE-1:0] dac_en,
    output logic [PW:0]   dac_cnt,
    output logic          dac_vld,
    output logic [PW-1:0] ptr_dbg
);

    logic [NE-1:0] dac_en_q, dac_en_d;
    logic [PW:0]   dac_cnt_q, dac_cnt_d;
    logic          dac_vld_q, dac_vld_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          dir_q, dir_d;
    logic [1:0]    mode_q, mode_d;

    logic [1:0]    mode_n;
    logic [PW:0]   k;
    logic [PW-1:0] ptr_e;
    logic          dir_e;
    logic [NE-1:0] vec;

    // Mode 11 is folded onto 01 so toggling between them is not seen as a mode change.
    always_comb begin
        mode_n = (mode == 2'b11) ? MODE_DWA : mode;
        k      = {din[NB-1], din} + OFFSET;
        ptr_e  = ptr_q;
        dir_e  = dir_q;
        if (mode_n != mode_q || mode_n == MODE_THERM) begin
            ptr_e = '0;
            dir_e = DIR_FWD;
        end
    end

    dwa_rotate #(
        .NE (NE),
        .PW (PW)
    ) u_rot (
        .k   (k),
        .ptr (ptr_e),
        .dir (dir_e),
        .vec (vec)
    );

    always_comb begin
        dac_en_d  = dac_en_q;
        dac_cnt_d = dac_cnt_q;
        dac_vld_d = 1'b0;
        ptr_d     = ptr_q;
        dir_d     = dir_q;
        mode_d    = mode_q;
        if (en) begin
            dac_en_d  = vec;
            dac_cnt_d = k;
            dac_vld_d = 1'b1;
            mode_d    = mode_n;
            case (mode_n)
                MODE_THERM: begin
                    ptr_d = '0;
                    dir_d = DIR_FWD;
                end
                MODE_BIDWA: begin
                    ptr_d = (dir_e == DIR_FWD) ? (ptr_e + k[PW-1:0]) : (ptr_e - k[PW-1:0]);
                    dir_d = ~dir_e;
                end
                default: begin
                    ptr_d = ptr_e + k[PW-1:0];
                    dir_d = DIR_FWD;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dac_en_q  <= '0;
            dac_cnt_q <= '0;
            dac_vld_q <= 1'b0;
            ptr_q     <= '0;
            dir_q     <= DIR_FWD;
            mode_q    <= MODE_THERM;
        end else begin
            dac_en_q  <= dac_en_d;
            dac_cnt_q <= dac_cnt_d;
            dac_vld_q <= dac_vld_d;
            ptr_q     <= ptr_d;
            dir_q     <= dir_d;
            mode_q    <= mode_d;
        end
    end

    assign dac_en  = dac_en_q;
    assign dac_cnt = dac_cnt_q;
    assign dac_vld = dac_vld_q;
    assign ptr_dbg = ptr_q;

endmodule

// File: tb/tb_sdm_dwa.sv
// Self-checking bench for sdm_dwa: directed scenarios plus randomized traffic against an element-list model.
module tb_sdm_dwa;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [3:0]  din;
    logic [15:0] dac_en;
    logic [4:0]  dac_cnt;
    logic        dac_vld;
    logic [3:0]  ptr_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state, kept as plain integers.
    int          m_ptr  = 0;
    int          m_bwd  = 0;
    int          m_mode = 0;
    logic [15:0] m_en   = '0;
    int          m_cnt  = 0;
    int          m_vld  = 0;

    sdm_dwa u_dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .din     (din),
        .dac_en  (dac_en),
        .dac_cnt (dac_cnt),
        .dac_vld (dac_vld),
        .ptr_dbg (ptr_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model(input logic r, input logic e, input logic [1:0] m, input logic [3:0] d);
        int mn, p, bwd, k, idx;
        if (r) begin
            m_ptr = 0; m_bwd = 0; m_mode = 0; m_en = '0; m_cnt = 0; m_vld = 0;
        end else if (!e) begin
            m_vld = 0;
        end else begin
            mn  = (m == 2'b11) ? 1 : int'(m);
            p   = m_ptr;
            bwd = m_bwd;
            if (mn != m_mode || mn == 0) begin
                p = 0; bwd = 0;
            end
            k    = int'($signed(d)) + 8;
            m_en = '0;
            for (int j = 0; j < k; j++) begin
                idx = (bwd == 0) ? (p + j) % 16 : (p - 1 - j + 32) % 16;
                m_en[idx] = 1'b1;
            end
            if (mn == 0) begin
                p = 0; bwd = 0;
            end else if (mn == 1) begin
                p = (p + k) % 16;
            end else begin
                p   = (bwd == 0) ? (p + k) % 16 : (p - k + 16) % 16;
                bwd = 1 - bwd;
            end
            m_ptr = p; m_bwd = bwd; m_mode = mn; m_cnt = k; m_vld = 1;
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [1:0] m, input logic [3:0] d);
        rst = r; en = e; mode = m; din = d;
        @(posedge clk);
        #1;
        model(r, e, m, d);
        check("dac_en", 32'(dac_en), 32'(m_en));
        check("dac_cnt", 32'(dac_cnt), 32'(m_cnt));
        check("dac_vld", 32'(dac_vld), 32'(m_vld));
        check("ptr", 32'(ptr_dbg), 32'(m_ptr));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; din = 4'h0;
        #1;

        // Reset with en high: rst wins.
        step(1'b1, 1'b1, 2'b01, 4'h3);
        check("rst_en", 32'(dac_en), 32'h0);
        check("rst_vld", 32'(dac_vld), 32'h0);

        // Forward DWA from reset.
        step(1'b0, 1'b1, 2'b01, 4'(-5));
        check("dwa1", 32'(dac_en), 32'h0007);
        check("dwa1_ptr", 32'(ptr_dbg), 32'd3);
        step(1'b0, 1'b1, 2'b01, 4'(-5));
        check("dwa2", 32'(dac_en), 32'h0038);
        check("dwa2_cnt", 32'(dac_cnt), 32'd3);

        // Wrap-around.
        step(1'b1, 1'b0, 2'b01, 4'h0);
        step(1'b0, 1'b1, 2'b01, 4'd6);
        check("wrap_pre", 32'(ptr_dbg), 32'd14);
        step(1'b0, 1'b1, 2'b01, 4'(-4));
        check("wrap", 32'(dac_en), 32'hC003);
        check("wrap_ptr", 32'(ptr_dbg), 32'd2);

        // Bidirectional.
        step(1'b1, 1'b0, 2'b10, 4'h0);
        step(1'b0, 1'b1, 2'b10, 4'(-5));
        check("bi1", 32'(dac_en), 32'h0007);
        step(1'b0, 1'b1, 2'b10, 4'(-6));
        check("bi2", 32'(dac_en), 32'h0006);
        check("bi2_ptr", 32'(ptr_dbg), 32'd1);

        // Thermometer and code extremes.
        step(1'b0, 1'b1, 2'b00, 4'd0);
        check("th_mid", 32'(dac_en), 32'h00FF);
        step(1'b0, 1'b1, 2'b00, 4'd7);
        check("th_max", 32'(dac_en), 32'h7FFF);
        check("th_max_cnt", 32'(dac_cnt), 32'd15);
        step(1'b0, 1'b1, 2'b00, 4'(-8));
        check("th_min", 32'(dac_en), 32'h0000);
        check("th_min_ptr", 32'(ptr_dbg), 32'd0);

        // Hold with en low, then resume; then switch 01 -> 10 at ptr=6.
        step(1'b0, 1'b1, 2'b01, 4'(-5));
        step(1'b0, 1'b1, 2'b01, 4'(-5));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2'b01, 4'($urandom_range(0, 15)));
        check("hold_en", 32'(dac_en), 32'h0038);
        check("hold_vld", 32'(dac_vld), 32'h0);
        step(1'b0, 1'b1, 2'b10, 4'(-6));
        check("mode_sw", 32'(dac_en), 32'h0003);

        // Randomized traffic: sticky mode with occasional switches, sparse resets.
        for (int i = 0; i < 400; i++) begin
            logic [1:0] m;
            m = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : mode;
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0), m,
                 4'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdm_dwa.md
Name: sdm_dwa

Overview:
- Dynamic-element-matching encoder directly downstream of the multi-bit sigma-delta modulator (`sdm`).
- Converts the modulator's signed `sdm_out` code into a unit-element enable vector for the 16-element current-steering DAC.
- Rotates element selection (data-weighted averaging, DWA) so element mismatch is first-order noise-shaped.
- Modes: plain thermometer (bypass), forward DWA, bidirectional DWA.

Parameters:
- NB, 4, width of the signed input code from the modulator.
- NE, 16, number of DAC unit elements; must equal 2**NB.
- PW, 4, pointer width, log2(NE).

Ports:
- clk  in  1  system clock; one sample per enabled cycle.
- rst  in  1  synchronous reset, active-high.
- en  in  1  sample strobe; when low, all state and outputs hold.
- mode  in  2  00 thermometer, 01 DWA, 10 bidirectional DWA, 11 treated as 01.
- din  in  NB  signed modulator code (`sdm_out`), range -8..7.
- dac_en  out  NE  registered unit-element enables; bit i drives element i.
- dac_cnt  out  PW+1  registered popcount of dac_en, for the checker.
- dac_vld  out  1  high the cycle after an enabled sample is encoded.
- ptr_dbg  out  PW  current rotation pointer.

Behaviour:
- Reset, applied at a clk edge while rst=1:
  - dac_en=0, dac_cnt=0, dac_vld=0, ptr=0, dir=forward, mode_q=00.
  - rst has priority over en.
- Element count: k = din + 2**(NB-1), unsigned 0..15, NB+1 bits. k=16 cannot occur.
- Latency: din/en/mode sampled at edge N; dac_en valid after edge N, and dac_vld=1 for that cycle.
- en=0 at an edge: dac_en, dac_cnt, ptr and dir hold; dac_vld<=0.
- Thermometer mode (00):
  - dac_en = elements 0..k-1 on.
  - ptr forced to 0 and dir to forward.
- DWA mode (01/11):
  - Elements ptr, ptr+1, ..., ptr+k-1 (mod NE) are on.
  - ptr <= (ptr+k) mod NE.
  - Wrap-around is natural PW-bit overflow.
- Bidirectional DWA mode (10):
  - dir toggles after every enabled sample.
  - Forward sample: as DWA.
  - Backward sample: elements ptr-1, ptr-2, ..., ptr-k (mod NE) are on, and ptr <= (ptr-k) mod NE.
- k=0 (din=-8): dac_en=0, ptr unchanged, dir still toggles in mode 10.
- Mode change: when the sampled mode differs from mode_q, the sample is encoded as if ptr=0 and dir=forward. mode_q is then updated.
- dac_cnt always equals k of the encoded sample; it equals popcount(dac_en) by construction.
- Vector generation is combinational from (ptr, k, dir): a thermometer mask of k ones, rotated left by ptr (forward) or right-aligned below ptr (backward).
- The only registers are the output and state registers. There is no internal pipelining.

Decomposition:
- Shared package `sdm_pkg`:
  - NB and NE constants.
  - Mode encodings MODE_THERM, MODE_DWA, MODE_BIDWA.
  - Offset constant 2**(NB-1).
- One natural sub-module, `dwa_rotate`: a combinational thermometer-mask generator plus barrel rotator (inputs k, ptr, dir; output NE-bit vector). It is reusable for other element counts.

Test Plan:
- Reset, mode=01, en=1, din=-5,-5 → dac_en=0x0007 (ptr→3), then 0x0038 (ptr→6); dac_cnt=3 both; dac_vld high from the first post-sample cycle.
- Wrap: mode=01, preload ptr=14 via din=6 (k=14) → next din=-4 (k=4) gives dac_en=0xC003, ptr→2.
- Bidirectional: reset, mode=10, din=-5 then -6 → 0x0007 (ptr→3, dir→bwd), then elements 2,1 = 0x0006 (ptr→1).
- Thermometer/extremes: mode=00, din=0 → 0x00FF; din=7 → 0x7FFF, cnt=15; din=-8 → 0x0000, ptr stays 0.
- Hold: mode=01 mid-stream, en=0 for 5 cycles with din changing → dac_en/ptr unchanged, dac_vld=0; the next enabled sample continues from the held ptr.
- Reset mid-operation and mode switch: rst pulse with en=1 → next edge dac_en=0, ptr=0. Switching 01→10 with ptr=6 → the first sample encodes from ptr=0 (din=-6 gives 0x0003).
